// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer
//   Cycles green / yellow / all-red phases around four directions (N, E, S, W).
//   Each phase is timed in seconds by a down-counter that advances on tick_1hz.
//   The phase ends when the counter reaches its terminal count of 1.
//
// Ports
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   tick_1hz          one-clk pulse per second
//   run               1 = sequence, 0 = freeze everything
//   green_duration    green time in seconds   (sampled at phase entry)
//   yellow_duration   yellow time in seconds  (sampled at phase entry)
//   red_holding       all-red gap in seconds  (0 skips the all-red phase)
//   active_direction  direction owning the phase (00=N 01=E 10=S 11=W)
//   countdown_sec     seconds left in the current phase
//   show_countdown    1 in GREEN and YELLOW
//   phase             00=IDLE 01=GREEN 10=YELLOW 11=ALL_RED
//   lights            2 bits per direction, 00=red 01=yellow 10=green
//   cycle_done        one-clk pulse when the direction wraps W -> N
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset; waits for run, all lights red, no countdown
// GREEN   | active direction green, counting down green time
// YELLOW  | active direction yellow, counting down yellow time
// ALL_RED | every direction red, counting down the gap before the next one

module traffic_phase_sequencer #(
   parameter int         MAX_SEC   = 99,
   parameter logic [1:0] START_DIR = 2'b00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       run,
   input  logic [7:0] green_duration,
   input  logic [7:0] yellow_duration,
   input  logic [7:0] red_holding,
   output logic [1:0] active_direction,
   output logic [7:0] countdown_sec,
   output logic       show_countdown,
   output logic [1:0] phase,
   output logic [7:0] lights,
   output logic       cycle_done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GREEN   = 2'b01,
      ST_YELLOW  = 2'b10,
      ST_ALL_RED = 2'b11
   } state_t;

   localparam logic [7:0] MAX_V = 8'(MAX_SEC);

   state_t     state_d, state_q;
   logic [1:0] dir_d, dir_q;
   logic [7:0] cnt_d, cnt_q;
   logic       show_d, show_q;
   logic [7:0] lights_d, lights_q;
   logic       done_d, done_q;

   logic [7:0] green_ld;
   logic [7:0] yellow_ld;
   logic [7:0] red_ld;
   logic       step;

   // Green and yellow never load 0 so a running phase always lasts at least
   // one second; red keeps 0 because 0 means "skip the all-red gap".
   function automatic logic [7:0] clamp_gy(input logic [7:0] v);
      if (v == 8'd0)
         return 8'd1;
      else if (v > MAX_V)
         return MAX_V;
      else
         return v;
   endfunction

   function automatic logic [7:0] clamp_red(input logic [7:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   always_comb begin
      green_ld  = clamp_gy(green_duration);
      yellow_ld = clamp_gy(yellow_duration);
      red_ld    = clamp_red(red_holding);
      step      = run && tick_1hz;

      state_d  = state_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // No tick needed to start, and a coincident tick is not applied.
            if (run) begin
               state_d = ST_GREEN;
               cnt_d   = green_ld;
            end
         end
         ST_GREEN: begin
            if (step) begin
               if (cnt_q > 8'd1) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  state_d = ST_YELLOW;
                  cnt_d   = yellow_ld;
               end
            end
         end
         ST_YELLOW: begin
            if (step) begin
               if (cnt_q > 8'd1) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (red_ld == 8'd0) begin
                  state_d = ST_GREEN;
                  cnt_d   = green_ld;
                  dir_d   = dir_q + 2'd1;
                  done_d  = (dir_q == 2'b11);
               end else begin
                  state_d = ST_ALL_RED;
                  cnt_d   = red_ld;
               end
            end
         end
         default: begin
            if (step) begin
               if (cnt_q > 8'd1) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  state_d = ST_GREEN;
                  cnt_d   = green_ld;
                  dir_d   = dir_q + 2'd1;
                  done_d  = (dir_q == 2'b11);
               end
            end
         end
      endcase

      // Display outputs are derived from the next state so that they are
      // registered alongside it and change on the same edge.
      show_d   = (state_d == ST_GREEN) || (state_d == ST_YELLOW);
      lights_d = 8'h00;
      if (state_d == ST_GREEN)
         lights_d[{dir_d, 1'b0} +: 2] = 2'b10;
      else if (state_d == ST_YELLOW)
         lights_d[{dir_d, 1'b0} +: 2] = 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= START_DIR;
         cnt_q    <= 8'd0;
         show_q   <= 1'b0;
         lights_q <= 8'h00;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         show_q   <= show_d;
         lights_q <= lights_d;
         done_q   <= done_d;
      end
   end

   assign phase            = state_q;
   assign active_direction = dir_q;
   assign countdown_sec    = cnt_q;
   assign show_countdown   = show_q;
   assign lights           = lights_q;
   assign cycle_done       = done_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer
//   Directed bench for traffic_phase_sequencer. Inputs change and outputs
//   are sampled on the falling clock edge; one tick pulse per 10 clocks.

module tb_traffic_phase_sequencer;

   logic       clk;
   logic       rst;
   logic       tick_1hz;
   logic       run;
   logic [7:0] green_duration;
   logic [7:0] yellow_duration;
   logic [7:0] red_holding;
   logic [1:0] active_direction;
   logic [7:0] countdown_sec;
   logic       show_countdown;
   logic [1:0] phase;
   logic [7:0] lights;
   logic       cycle_done;

   int checks;
   int failures;
   int cd_count;
   logic [1:0] cd_dir;
   logic saw_all_red;

   traffic_phase_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .tick_1hz         (tick_1hz),
      .run              (run),
      .green_duration   (green_duration),
      .yellow_duration  (yellow_duration),
      .red_holding      (red_holding),
      .active_direction (active_direction),
      .countdown_sec    (countdown_sec),
      .show_countdown   (show_countdown),
      .phase            (phase),
      .lights           (lights),
      .cycle_done       (cycle_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cycle_done === 1'b1) begin
         cd_count = cd_count + 1;
         cd_dir   = active_direction;
      end
      if (phase === 2'b11)
         saw_all_red = 1'b1;
   end

   task automatic pulse_tick();
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      repeat (9) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      run      = 1'b0;
      tick_1hz = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cd_count    = 0;
      saw_all_red = 1'b0;
   endtask

   task automatic start_run();
      run = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; tick_1hz = 1'b1;
      green_duration = 8'd5; yellow_duration = 8'd3; red_holding = 8'd2;
      repeat (3) @(negedge clk);
      checks++;
      if (phase !== 2'b00 || active_direction !== 2'b00 || countdown_sec !== 8'd0 ||
          show_countdown !== 1'b0 || lights !== 8'h00 || cycle_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: phase=%b dir=%b cnt=%0d show=%b lights=%h done=%b, required 00 00 0 0 00 0",
                  phase, active_direction, countdown_sec, show_countdown, lights, cycle_done);
      end
      rst = 1'b0; run = 1'b0; tick_1hz = 1'b0;
      repeat (5) @(negedge clk);
      tick_1hz = 1'b1; @(negedge clk); tick_1hz = 1'b0;
      checks++;
      if (phase !== 2'b00 || countdown_sec !== 8'd0) begin
         failures++;
         $display("FAIL idle_hold: phase=%b cnt=%0d, required 00 0", phase, countdown_sec);
      end
   endtask

   // Columns: phase, countdown, direction, lights after each tick.
   task automatic test_basic_sequence();
      logic [1:0] e_ph  [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
      logic [7:0] e_cnt [10] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd5};
      logic [1:0] e_dir [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      logic [7:0] e_lt  [10] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h08};
      logic       e_sh  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      apply_reset();
      green_duration = 8'd5; yellow_duration = 8'd3; red_holding = 8'd2;
      // Tick coincides with the IDLE->GREEN edge and must not be applied.
      run = 1'b1; tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      checks++;
      if (phase !== 2'b01 || countdown_sec !== 8'd5 || lights !== 8'h02 || show_countdown !== 1'b1) begin
         failures++;
         $display("FAIL start_green: phase=%b cnt=%0d lights=%h show=%b, required 01 5 02 1",
                  phase, countdown_sec, lights, show_countdown);
      end
      repeat (9) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         pulse_tick();
         checks++;
         if (phase !== e_ph[i] || countdown_sec !== e_cnt[i] || active_direction !== e_dir[i] ||
             lights !== e_lt[i] || show_countdown !== e_sh[i]) begin
            failures++;
            $display("FAIL basic_step%0d: phase=%b cnt=%0d dir=%b lights=%h show=%b, required %b %0d %b %h %b",
                     i, phase, countdown_sec, active_direction, lights, show_countdown,
                     e_ph[i], e_cnt[i], e_dir[i], e_lt[i], e_sh[i]);
         end
      end
   endtask

   task automatic test_clamp();
      apply_reset();
      green_duration = 8'd0; yellow_duration = 8'd150; red_holding = 8'd2;
      start_run();
      checks++;
      if (countdown_sec !== 8'd1 || phase !== 2'b01) begin
         failures++;
         $display("FAIL clamp_green0: cnt=%0d phase=%b, required 1 01", countdown_sec, phase);
      end
      pulse_tick();
      checks++;
      if (countdown_sec !== 8'd99 || phase !== 2'b10) begin
         failures++;
         $display("FAIL clamp_yellow_max: cnt=%0d phase=%b, required 99 10", countdown_sec, phase);
      end
      apply_reset();
      green_duration = 8'd200; yellow_duration = 8'd0; red_holding = 8'd200;
      start_run();
      checks++;
      if (countdown_sec !== 8'd99) begin
         failures++;
         $display("FAIL clamp_green_max: cnt=%0d, required 99", countdown_sec);
      end
      green_duration = 8'd1;
      pulse_tick();
      checks++;
      if (countdown_sec !== 8'd98) begin
         failures++;
         $display("FAIL decrement_from_max: cnt=%0d, required 98", countdown_sec);
      end
      apply_reset();
      start_run();
      pulse_tick();
      checks++;
      if (countdown_sec !== 8'd1 || phase !== 2'b10) begin
         failures++;
         $display("FAIL clamp_yellow0: cnt=%0d phase=%b, required 1 10", countdown_sec, phase);
      end
      pulse_tick();
      checks++;
      if (countdown_sec !== 8'd99 || phase !== 2'b11 || show_countdown !== 1'b0) begin
         failures++;
         $display("FAIL clamp_red_max: cnt=%0d phase=%b show=%b, required 99 11 0",
                  countdown_sec, phase, show_countdown);
      end
   endtask

   task automatic test_freeze();
      apply_reset();
      green_duration = 8'd5; yellow_duration = 8'd3; red_holding = 8'd2;
      start_run();
      pulse_tick();
      run = 1'b0;
      repeat (5) pulse_tick();
      checks++;
      if (countdown_sec !== 8'd4 || active_direction !== 2'b00 || phase !== 2'b01) begin
         failures++;
         $display("FAIL freeze_hold: cnt=%0d dir=%b phase=%b, required 4 00 01",
                  countdown_sec, active_direction, phase);
      end
      run = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (countdown_sec !== 8'd4) begin
         failures++;
         $display("FAIL freeze_no_buffer: cnt=%0d, required 4", countdown_sec);
      end
      pulse_tick();
      checks++;
      if (countdown_sec !== 8'd3) begin
         failures++;
         $display("FAIL freeze_resume: cnt=%0d, required 3", countdown_sec);
      end
   endtask

   task automatic test_mid_change();
      apply_reset();
      green_duration = 8'd5; yellow_duration = 8'd1; red_holding = 8'd1;
      start_run();
      pulse_tick();
      green_duration = 8'd9;
      repeat (3) pulse_tick();
      checks++;
      if (countdown_sec !== 8'd1 || phase !== 2'b01) begin
         failures++;
         $display("FAIL midchange_keep: cnt=%0d phase=%b, required 1 01", countdown_sec, phase);
      end
      repeat (3) pulse_tick();
      checks++;
      if (countdown_sec !== 8'd9 || phase !== 2'b01 || active_direction !== 2'b01) begin
         failures++;
         $display("FAIL midchange_load: cnt=%0d phase=%b dir=%b, required 9 01 01",
                  countdown_sec, phase, active_direction);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      green_duration = 8'd1; yellow_duration = 8'd1; red_holding = 8'd1;
      start_run();
      repeat (12) pulse_tick();
      checks++;
      if (cd_count !== 1 || cd_dir !== 2'b00 || active_direction !== 2'b00 || phase !== 2'b01) begin
         failures++;
         $display("FAIL wrap_via_all_red: pulses=%0d dir_at_pulse=%b dir=%b phase=%b, required 1 00 00 01",
                  cd_count, cd_dir, active_direction, phase);
      end
   endtask

   task automatic test_red_zero();
      apply_reset();
      green_duration = 8'd1; yellow_duration = 8'd1; red_holding = 8'd0;
      start_run();
      for (int d = 0; d < 4; d++) begin
         pulse_tick();
         pulse_tick();
         checks++;
         if (phase !== 2'b01 || active_direction !== 2'(d + 1)) begin
            failures++;
            $display("FAIL red_zero_dir%0d: phase=%b dir=%b, required 01 %b",
                     d, phase, active_direction, 2'(d + 1));
         end
      end
      checks++;
      if (saw_all_red !== 1'b0) begin
         failures++;
         $display("FAIL red_zero_no_allred: saw ALL_RED=%b, required 0", saw_all_red);
      end
      pulse_tick();
      pulse_tick();
      pulse_tick();
      checks++;
      if (phase !== 2'b10 || active_direction !== 2'b01) begin
         failures++;
         $display("FAIL east_yellow: phase=%b dir=%b, required 10 01", phase, active_direction);
      end
      rst = 1'b1; tick_1hz = 1'b1;
      @(negedge clk);
      rst = 1'b0; tick_1hz = 1'b0; run = 1'b0;
      checks++;
      if (phase !== 2'b00 || countdown_sec !== 8'd0 || lights !== 8'h00 ||
          active_direction !== 2'b00 || show_countdown !== 1'b0) begin
         failures++;
         $display("FAIL midphase_reset: phase=%b cnt=%0d lights=%h dir=%b show=%b, required 00 0 00 00 0",
                  phase, countdown_sec, lights, active_direction, show_countdown);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cd_count !== 1 || cd_dir !== 2'b00) begin
         failures++;
         $display("FAIL cycle_done_once: pulses=%0d dir_at_pulse=%b, required 1 00", cd_count, cd_dir);
      end
   endtask

   initial begin
      checks = 0; failures = 0; cd_count = 0; cd_dir = 2'b00; saw_all_red = 1'b0;
      rst = 1'b1; run = 1'b0; tick_1hz = 1'b0;
      green_duration = 8'd0; yellow_duration = 8'd0; red_holding = 8'd0;
      test_reset();
      test_basic_sequence();
      test_clamp();
      test_freeze();
      test_mid_change();
      test_back_to_back();
      test_red_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
